// File: rtl/io_display_responder.sv
// io_display_responder
//   Memory-mapped IO responder for the display value, board switches and
//   status. A DISPLAY write starts a sequential double-dabble conversion of
//   the signed value to ten packed BCD digits plus a sign, one shift per
//   cycle; the digits and sign are committed only once the conversion ends.
//
// Ports
//   clk        system clock, rising edge
//   rstIO      asynchronous active-low reset
//   addressIO  byte offset within the IO window (bits [3:2] decoded)
//   dataInIO   write data
//   wEnIO      write strobe
//   dataOutIO  combinational read data
//   sw         asynchronous board switches
//   bcdDigits  ten BCD digits, digit 0 (units) in bits [3:0]
//   neg        sign of the displayed value
//   busy       conversion in progress
module io_display_responder #(
    parameter int unsigned IO_ADDR_BITS = 4,
    parameter int unsigned SW_BITS      = 10
) (
    input  logic                    clk,
    input  logic                    rstIO,
    input  logic [IO_ADDR_BITS-1:0] addressIO,
    input  logic [31:0]             dataInIO,
    input  logic                    wEnIO,
    output logic [31:0]             dataOutIO,
    input  logic [SW_BITS-1:0]      sw,
    output logic [39:0]             bcdDigits,
    output logic                    neg,
    output logic                    busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIGITS = 10;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = 5;

    localparam logic [1:0]       REG_DISPLAY  = 2'd0;
    localparam logic [1:0]       REG_STATUS   = 2'd1;
    localparam logic [1:0]       REG_SWITCHES = 2'd2;
    localparam logic [1:0]       REG_DIGITS   = 2'd3;
    localparam logic [CNT_W-1:0] LAST_SHIFT   = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   display_q, display_d;
    logic [DATA_W-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]    acc_q, acc_d, acc_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic                overrun_q, overrun_d;
    logic                busy_d, neg_d;
    logic [BCD_W-1:0]    digits_d;
    logic [SW_BITS-1:0]  sw_meta_q, sw_sync_q;

    logic                display_wr, status_wr;
    logic                unused_addr;

    // Low address bits (and any bits above [3:2]) are intentionally not decoded
    assign unused_addr = &{1'b0, addressIO};

    assign display_wr = wEnIO && (addressIO[3:2] == REG_DISPLAY);
    assign status_wr  = wEnIO && (addressIO[3:2] == REG_STATUS);

    // Double-dabble correction: +3 on every digit >= 5 before the shift
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        display_d = display_q;
        mag_d     = mag_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        overrun_d = overrun_q;
        busy_d    = busy;
        neg_d     = neg;
        digits_d  = bcdDigits;

        if (status_wr && dataInIO[1]) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                acc_d = {acc_adj[BCD_W-2:0], mag_q[DATA_W-1]};
                mag_d = {mag_q[DATA_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SHIFT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                digits_d = acc_q;
                neg_d    = sign_q;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new value always wins: abort any conversion, including its commit
        if (display_wr) begin
            display_d = dataInIO;
            sign_d    = dataInIO[31];
            mag_d     = dataInIO[31] ? (~dataInIO + DATA_W'(1)) : dataInIO;
            acc_d     = '0;
            cnt_d     = '0;
            busy_d    = 1'b1;
            digits_d  = bcdDigits;
            neg_d     = neg;
            state_d   = ST_SHIFT;
            if (state_q != ST_IDLE) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstIO) begin
        if (!rstIO) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, committed outputs and switch synchronizer
    always_ff @(posedge clk or negedge rstIO) begin
        if (!rstIO) begin
            display_q <= '0;
            mag_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            overrun_q <= 1'b0;
            busy      <= 1'b0;
            neg       <= 1'b0;
            bcdDigits <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            display_q <= display_d;
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            overrun_q <= overrun_d;
            busy      <= busy_d;
            neg       <= neg_d;
            bcdDigits <= digits_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Read mux, no side effects
    always_comb begin
        dataOutIO = '0;
        case (addressIO[3:2])
            REG_DISPLAY:  dataOutIO = display_q;
            REG_STATUS:   dataOutIO = {16'h0000, bcdDigits[39:32], 5'b00000,
                                       neg, overrun_q, busy};
            REG_SWITCHES: dataOutIO = DATA_W'(sw_sync_q);
            REG_DIGITS:   dataOutIO = bcdDigits[31:0];
            default:      dataOutIO = '0;
        endcase
    end

endmodule
